// File: rtl/maxim_window.sv
// Windowed running-maximum detector for 2-axis ADC samples {X,Y}; classifies the
// window peak against amplitude thresholds and strobes the downstream arctg stage.
module maxim_window #(
  parameter int unsigned DW       = 12,
  parameter int unsigned WIN_LEN  = 1000,
  parameter int unsigned THR_LOW  = 31,
  parameter int unsigned THR_HIGH = 255,
  parameter int unsigned CMP_MODE = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en_maxim,
  input  logic [2*DW-1:0]            es_adc,
  input  logic                       win_clear,
  output logic [1:0]                 en_arctg,
  output logic [2*DW-1:0]            max_date_adc,
  output logic [$clog2(WIN_LEN)-1:0] max_idx,
  output logic                       busy
);

  localparam int unsigned IW = $clog2(WIN_LEN);
  localparam logic [IW-1:0] LastIdx = IW'(WIN_LEN - 1);
  localparam logic [DW-1:0] ThrLow  = DW'(THR_LOW);
  localparam logic [DW-1:0] ThrHigh = DW'(THR_HIGH);

  typedef enum logic {StAcq, StDecide} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   count_q, count_d;
  logic [IW-1:0]   aux_idx_q, aux_idx_d;
  logic [IW-1:0]   max_idx_q, max_idx_d;
  logic [2*DW-1:0] aux_q, aux_d;
  logic [2*DW-1:0] max_q, max_d;
  logic [1:0]      en_q, en_d;

  logic [DW-1:0] x_in, y_in, aux_x, aux_y;
  logic [DW:0]   sum_in, sum_aux;
  logic          upd, peak_valid;

  always_comb begin
    x_in    = es_adc[2*DW-1:DW];
    y_in    = es_adc[DW-1:0];
    aux_x   = aux_q[2*DW-1:DW];
    aux_y   = aux_q[DW-1:0];
    // Sums carry one extra bit so large samples never wrap.
    sum_in  = {1'b0, x_in} + {1'b0, y_in};
    sum_aux = {1'b0, aux_x} + {1'b0, aux_y};
    upd     = 1'b0;
    if (CMP_MODE == 0) begin
      upd = (x_in >= aux_x) && (y_in >= aux_y);
    end else begin
      upd = (sum_in >= sum_aux);
    end
    peak_valid = ((aux_x > ThrLow) && (aux_y > ThrLow)) ||
                 ((aux_x > ThrHigh) && (aux_y < ThrLow)) ||
                 ((aux_x < ThrLow) && (aux_y > ThrHigh));
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    aux_d     = aux_q;
    aux_idx_d = aux_idx_q;
    max_d     = max_q;
    max_idx_d = max_idx_q;
    en_d      = 2'b00;
    if (win_clear) begin
      state_d   = StAcq;
      count_d   = '0;
      aux_d     = '0;
      aux_idx_d = '0;
    end else begin
      unique case (state_q)
        StAcq: begin
          if (en_maxim) begin
            if (upd) begin
              aux_d     = es_adc;
              aux_idx_d = count_q;
            end
            if (count_q == LastIdx) begin
              count_d = '0;
              state_d = StDecide;
            end else begin
              count_d = count_q + 1'b1;
            end
          end
        end
        StDecide: begin
          if (peak_valid) begin
            max_d     = aux_q;
            max_idx_d = aux_idx_q;
            en_d      = 2'b11;
          end else begin
            max_d     = '0;
            max_idx_d = '0;
            en_d      = 2'b01;
          end
          aux_d     = '0;
          aux_idx_d = '0;
          state_d   = StAcq;
        end
        default: state_d = StAcq;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StAcq;
      count_q   <= '0;
      aux_q     <= '0;
      aux_idx_q <= '0;
      max_q     <= '0;
      max_idx_q <= '0;
      en_q      <= 2'b00;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      aux_q     <= aux_d;
      aux_idx_q <= aux_idx_d;
      max_q     <= max_d;
      max_idx_q <= max_idx_d;
      en_q      <= en_d;
    end
  end

  assign en_arctg     = en_q;
  assign max_date_adc = max_q;
  assign max_idx      = max_idx_q;
  assign busy         = (state_q == StDecide);

endmodule

// File: tb/tb_maxim_window.sv
// Bench for maxim_window: two instances (joint-max and sum-max) share stimulus and are
// checked against a window-level reference model plus a table of hand-derived windows.
module tb_maxim_window;

  localparam int WL = 8;

  logic        clk, rst, en_maxim, win_clear;
  logic [23:0] es_adc;
  logic [1:0]  en0, en1;
  logic [23:0] max0, max1;
  logic [2:0]  idx0, idx1;
  logic        busy0, busy1;

  maxim_window #(.DW(12), .WIN_LEN(WL), .THR_LOW(31), .THR_HIGH(255), .CMP_MODE(0)) u_dut0 (
    .clk(clk), .rst(rst), .en_maxim(en_maxim), .es_adc(es_adc), .win_clear(win_clear),
    .en_arctg(en0), .max_date_adc(max0), .max_idx(idx0), .busy(busy0)
  );

  maxim_window #(.DW(12), .WIN_LEN(WL), .THR_LOW(31), .THR_HIGH(255), .CMP_MODE(1)) u_dut1 (
    .clk(clk), .rst(rst), .en_maxim(en_maxim), .es_adc(es_adc), .win_clear(win_clear),
    .en_arctg(en1), .max_date_adc(max1), .max_idx(idx1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: collects the accepted samples of the current window.
  logic [23:0] win_q[$];
  bit          pending;
  logic [1:0]  x_en0, x_en1;
  logic [23:0] x_max0, x_max1;
  logic [2:0]  x_idx0, x_idx1;

  function automatic logic [23:0] xy(input int x, input int y);
    return {12'(x), 12'(y)};
  endfunction

  function automatic bit classify(input logic [23:0] v);
    int x, y;
    x = int'(v[23:12]);
    y = int'(v[11:0]);
    return (x > 31 && y > 31) || (x > 255 && y < 31) || (x < 31 && y > 255);
  endfunction

  task automatic model_reset();
    win_q.delete();
    pending = 0;
    x_en0 = 0; x_en1 = 0; x_max0 = 0; x_max1 = 0; x_idx0 = 0; x_idx1 = 0;
  endtask

  task automatic model_decide();
    int bx, by, bi, bs, si;
    bx = 0; by = 0; bi = 0;
    foreach (win_q[i]) begin
      if (int'(win_q[i][23:12]) >= bx && int'(win_q[i][11:0]) >= by) begin
        bx = int'(win_q[i][23:12]); by = int'(win_q[i][11:0]); bi = i;
      end
    end
    if (classify(xy(bx, by))) begin
      x_en0 = 2'b11; x_max0 = xy(bx, by); x_idx0 = 3'(bi);
    end else begin
      x_en0 = 2'b01; x_max0 = 0; x_idx0 = 0;
    end
    // Sum mode: last index holding the largest X+Y.
    bs = -1; si = 0;
    foreach (win_q[i]) begin
      if (int'(win_q[i][23:12]) + int'(win_q[i][11:0]) >= bs) begin
        bs = int'(win_q[i][23:12]) + int'(win_q[i][11:0]); si = i;
      end
    end
    if (classify(win_q[si])) begin
      x_en1 = 2'b11; x_max1 = win_q[si]; x_idx1 = 3'(si);
    end else begin
      x_en1 = 2'b01; x_max1 = 0; x_idx1 = 0;
    end
  endtask

  task automatic model_edge();
    if (win_clear) begin
      win_q.delete(); pending = 0; x_en0 = 0; x_en1 = 0;
    end else if (pending) begin
      model_decide();
      win_q.delete(); pending = 0;
    end else begin
      x_en0 = 0; x_en1 = 0;
      if (en_maxim) begin
        win_q.push_back(es_adc);
        if (win_q.size() == WL) pending = 1;
      end
    end
  endtask

  task automatic check_all();
    chk("en_arctg0", 32'(en0), 32'(x_en0));
    chk("max0", 32'(max0), 32'(x_max0));
    chk("idx0", 32'(idx0), 32'(x_idx0));
    chk("busy0", 32'(busy0), 32'(pending));
    chk("en_arctg1", 32'(en1), 32'(x_en1));
    chk("max1", 32'(max1), 32'(x_max1));
    chk("idx1", 32'(idx1), 32'(x_idx1));
    chk("busy1", 32'(busy1), 32'(pending));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  function automatic logic [11:0] rnd_axis();
    case ($urandom % 4)
      0: return 12'($urandom_range(0, 40));
      1: return 12'($urandom_range(250, 260));
      2: return 12'd31;
      default: return 12'($urandom % 4096);
    endcase
  endfunction

  typedef struct packed {
    logic [7:0][23:0] s;
    logic [1:0]       en0;
    logic [23:0]      m0;
    logic [2:0]       i0;
    logic [1:0]       en1;
    logic [23:0]      m1;
    logic [2:0]       i1;
  } vec_t;

  vec_t tv[8];

  task automatic apply_window(input vec_t v, input int gap_max, input bit en_in_decide);
    for (int k = 0; k < WL; k++) begin
      for (int g = $urandom_range(0, gap_max); g > 0; g--) begin
        en_maxim = 1'b0; es_adc = xy(4000, 4000);
        step();
      end
      en_maxim = 1'b1; es_adc = v.s[k];
      step();
    end
    chk("busy_after_last", 32'(busy0), 32'd1);
    chk("no_strobe_at_E0", 32'(en0), 32'd0);
    en_maxim = en_in_decide; es_adc = xy(4000, 4000);
    step();
    chk("tbl_en0", 32'(en0), 32'(v.en0));
    chk("tbl_max0", 32'(max0), 32'(v.m0));
    chk("tbl_idx0", 32'(idx0), 32'(v.i0));
    chk("tbl_en1", 32'(en1), 32'(v.en1));
    chk("tbl_max1", 32'(max1), 32'(v.m1));
    chk("tbl_idx1", 32'(idx1), 32'(v.i1));
    chk("busy_after_E1", 32'(busy0), 32'd0);
    en_maxim = 1'b0;
  endtask

  task automatic feed(input int n, input logic [23:0] val);
    for (int k = 0; k < n; k++) begin
      en_maxim = 1'b1; es_adc = val;
      step();
    end
    en_maxim = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) tv[i] = '0;
    for (int k = 0; k < WL; k++) tv[0].s[k] = xy(40 * (k + 1), 40 * (k + 1));
    tv[0].en0 = 2'b11; tv[0].m0 = xy(320, 320); tv[0].i0 = 7;
    tv[0].en1 = 2'b11; tv[0].m1 = xy(320, 320); tv[0].i1 = 7;
    for (int k = 0; k < WL; k++) tv[1].s[k] = xy(10, 10);
    tv[1].en0 = 2'b01; tv[1].en1 = 2'b01;
    for (int k = 0; k < WL; k++) tv[2].s[k] = xy(31, 31);
    tv[2].en0 = 2'b01; tv[2].en1 = 2'b01;
    tv[3].s[3] = xy(300, 5);
    tv[3].en0 = 2'b11; tv[3].m0 = xy(300, 5); tv[3].i0 = 3;
    tv[3].en1 = 2'b11; tv[3].m1 = xy(300, 5); tv[3].i1 = 3;
    tv[4].s[3] = xy(5, 300);
    tv[4].en0 = 2'b11; tv[4].m0 = xy(5, 300); tv[4].i0 = 3;
    tv[4].en1 = 2'b11; tv[4].m1 = xy(5, 300); tv[4].i1 = 3;
    tv[5].s[0] = xy(400, 40); tv[5].s[1] = xy(200, 300);
    tv[5].en0 = 2'b11; tv[5].m0 = xy(400, 40);  tv[5].i0 = 0;
    tv[5].en1 = 2'b11; tv[5].m1 = xy(200, 300); tv[5].i1 = 1;
    tv[6].s[2] = xy(100, 100); tv[6].s[5] = xy(100, 100);
    tv[6].en0 = 2'b11; tv[6].m0 = xy(100, 100); tv[6].i0 = 5;
    tv[6].en1 = 2'b11; tv[6].m1 = xy(100, 100); tv[6].i1 = 5;
    for (int k = 0; k < WL; k++) tv[7].s[k] = xy(50, 50);
    tv[7].en0 = 2'b11; tv[7].m0 = xy(50, 50); tv[7].i0 = 7;
    tv[7].en1 = 2'b11; tv[7].m1 = xy(50, 50); tv[7].i1 = 7;

    rst = 1'b1; en_maxim = 1'b0; win_clear = 1'b0; es_adc = '0;
    model_reset();
    #2;
    check_all();
    @(posedge clk); #1;
    rst = 1'b0;

    // Window 6 has random gaps and en_maxim held through DECIDE; window 7 follows directly.
    for (int i = 0; i < 8; i++) apply_window(tv[i], (i == 6) ? 3 : 0, i == 6);

    // win_clear after 5 samples, alone and together with en_maxim.
    feed(5, xy(500, 500));
    win_clear = 1'b1; step(); win_clear = 1'b0;
    apply_window(tv[1], 0, 0);
    feed(5, xy(500, 500));
    win_clear = 1'b1; en_maxim = 1'b1; es_adc = xy(4000, 4000); step();
    win_clear = 1'b0; en_maxim = 1'b0;
    apply_window(tv[3], 0, 0);

    // win_clear landing on DECIDE suppresses the strobe and keeps outputs.
    feed(WL, xy(600, 600));
    win_clear = 1'b1; step(); win_clear = 1'b0;
    chk("clear_in_decide_en", 32'(en0), 32'd0);
    chk("clear_in_decide_max", 32'(max0), 32'(xy(300, 5)));
    apply_window(tv[4], 0, 0);

    // Async reset mid-window clears outputs without a clock edge.
    feed(3, xy(700, 700));
    #2 rst = 1'b1;
    #1;
    chk("rst_async_en", 32'(en0), 32'd0);
    chk("rst_async_max", 32'(max0), 32'd0);
    chk("rst_async_idx", 32'(idx0), 32'd0);
    chk("rst_async_busy", 32'(busy0), 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    apply_window(tv[5], 0, 0);

    for (int c = 0; c < 600; c++) begin
      en_maxim  = ($urandom % 3) != 0;
      win_clear = ($urandom % 40) == 0;
      es_adc    = {rnd_axis(), rnd_axis()};
      step();
    end
    en_maxim = 1'b0; win_clear = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/maxim_window.md
Name: maxim_window

Overview:
Parametrised successor of the window peak detector. Streams 2-axis ADC samples (X in the upper half, Y in the lower half), tracks the running maximum over a window of WIN_LEN accepted samples and classifies it against amplitude thresholds. Emits the result plus a one-cycle strobe to the downstream arctg/CORDIC stage. Replaces the full-window shift register with on-the-fly comparison, so a new window starts immediately after each decision.

Parameters:
DW, 12, width of each axis sample (unsigned)
WIN_LEN, 1000, accepted samples per window (>=2)
THR_LOW, 31, low amplitude threshold (~0.025-0.05 V)
THR_HIGH, 255, high threshold for the single-axis (0/90 deg) cases
CMP_MODE, 0, 0 = joint max (both axes >= current max); 1 = max of X+Y

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
en_maxim  in  1  sample strobe; es_adc is accepted on a clk edge where en_maxim=1
es_adc  in  2*DW  {X[2*DW-1:DW], Y[DW-1:0]}, unsigned
win_clear  in  1  synchronous abort of the current partial window
en_arctg  out  2  decision strobe: 2'b11 = valid max, 2'b01 = indeterminate, 2'b00 = idle
max_date_adc  out  2*DW  registered {X,Y} of the window maximum
max_idx  out  $clog2(WIN_LEN)  position in the window of the retained maximum
busy  out  1  high in DECIDE; samples offered then are dropped

Behaviour:
- Async reset (rst=1): state=ACQ, count=0, running max aux=0, aux_idx=0, en_arctg=00, max_date_adc=0, max_idx=0, busy=0.
- States:
  - ACQ: on each accepted sample, run the compare, then increment count.
    - If count==WIN_LEN-1 on that sample: count<=0, go to DECIDE (the last sample is included in the compare).
  - DECIDE (exactly 1 cycle): classify aux, register outputs, pulse en_arctg, clear aux/aux_idx to 0, return to ACQ.
- Compare, CMP_MODE=0:
  - Update when X>=aux.X and Y>=aux.Y (unsigned).
- Compare, CMP_MODE=1:
  - Update when X+Y >= aux.X+aux.Y, with the sum computed in DW+1 bits (no overflow).
- Compare, both modes:
  - Ties take the newer sample.
  - aux starts at 0, so the first sample of a window always loads.
  - On update, aux_idx<=count.
- Classification, strict comparisons, in priority order:
  - (a) X>THR_LOW and Y>THR_LOW
  - (b) X>THR_HIGH and Y<THR_LOW (0 deg)
  - (c) X<THR_LOW and Y>THR_HIGH (90 deg)
  - (a)/(b)/(c) -> max_date_adc<=aux, max_idx<=aux_idx, en_arctg=11.
  - Otherwise -> max_date_adc<=0, max_idx<=0, en_arctg=01.
  - An axis exactly equal to THR_LOW therefore fails (a).
- Timing: edge E0 accepts the last sample; edge E1 (state DECIDE) registers the result.
  - en_arctg is non-zero only between E1 and E2, for exactly one cycle; otherwise it is 00.
  - busy=1 only between E0 and E1.
  - The earliest sample of the next window is accepted at E1 or later, because state is ACQ after E1.
- max_date_adc and max_idx hold their value until the next decision.
- en_maxim during DECIDE: the sample is ignored and does not count.
- Gaps in en_maxim: allowed, no timeout; count advances only on accepted samples.
- win_clear=1: count<=0, aux<=0, aux_idx<=0, state<=ACQ. Outputs are unchanged.
  - If asserted in DECIDE: no strobe, outputs unchanged.
  - Priority over en_maxim in the same cycle; the sample is dropped.
- Reset mid-window discards the partial window. The next decision needs WIN_LEN fresh samples.

Test Plan:
- WIN_LEN=8, X=Y=40*k for k=1..8 back-to-back -> en_arctg=11 for one cycle, 2 edges after the 8th sample; max_date_adc={320,320}, max_idx=7; busy high 1 cycle.
- WIN_LEN=8, all samples X=Y=10 -> en_arctg=01, max_date_adc=0, max_idx=0; repeat with X=Y=31 (boundary) -> still 01.
- WIN_LEN=8, zeros except (300,5) at position 3 -> en_arctg=11 (0 deg case), max_date_adc={300,5}, max_idx=3; mirror (5,300) -> 11 (90 deg).
- WIN_LEN=8, random gaps in en_maxim, equal max (100,100) at positions 2 and 5 -> max_idx=5; en_maxim held high through DECIDE -> that sample is not counted; next window completes after exactly 8 further accepts.
- Samples (400,40) then (200,300), rest zero: CMP_MODE=0 -> max {400,40}; CMP_MODE=1 -> max {200,300}; both with en_arctg=11.
- After 5 samples: win_clear pulse (also asserted together with en_maxim) -> no strobe until 8 new accepts. rst asserted mid-window -> all outputs 0 immediately (async); same 8-sample rule after release.
